// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared definitions for the uart byte path: the uart data width, the byte
// type reused by the transmitter and the RX-side consumer, and a constant
// ceil(log2) helper for sizing pointers and counters.
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

   // ceil(log2(value)); fixed loop bound keeps it usable as a constant function
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_tx_fifo_mem_dp.sv
// ---------------------------------------------------------------------------
// fifo_mem_dp
// DEPTH x DATA_W register array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk_i    system clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address (combinational read)
//   rdata_o  read data
// ---------------------------------------------------------------------------
module fifo_mem_dp #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8,
   parameter int AW     = 4
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem_dp

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Circular byte FIFO feeding the uart transmitter through a valid/ready
// handshake, with a registered show-ahead output stage.
//   CLK      system clock, rising edge
//   RSTn     asynchronous active-low reset
//   wr_en    write strobe (one byte per cycle), wr_data byte to enqueue
//   flush    synchronous clear of contents and pointers
//   err_clr  clears sticky ovf/unf (a same-cycle error event wins)
//   tx_ready uart accepts tx_data this cycle
//   tx_valid / tx_data  head byte presented to the uart
//   full / empty / level / low_irq  occupancy status
//   ovf      sticky: write attempted while full
//   unf      sticky: tx_ready while tx_valid low
// ---------------------------------------------------------------------------
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W,
   parameter int LOW_WM = 4
) (
   input  logic                      CLK,
   input  logic                      RSTn,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      flush,
   input  logic                      err_clr,
   input  logic                      tx_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(DEPTH):0]     level,
   output logic                      low_irq,
   output logic                      ovf,
   output logic                      unf
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              tx_valid_q, tx_valid_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              full_w;
   logic              rd_ok;
   logic              wr_ok;
   logic [DATA_W-1:0] mem_rdata;

   assign full_w = (level_q == LW'(DEPTH));
   assign rd_ok  = tx_valid_q && tx_ready && !flush;
   // A read in the same cycle frees a slot, so a write into a full FIFO is
   // accepted when the head is leaving.
   assign wr_ok  = wr_en && !flush && (!full_w || rd_ok);

   // Read port looks at the head *after* this edge so the output register
   // can be loaded with the next byte at the same time rd_ptr advances.
   fifo_mem_dp #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_mem (
      .clk_i   (CLK),
      .we_i    (wr_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_d),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         tx_valid_d = 1'b0;
      end else begin
         if (wr_en && !wr_ok)        ovf_d = 1'b1;
         if (tx_ready && !tx_valid_q) unf_d = 1'b1;

         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);

         case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase

         tx_valid_d = (level_d != '0);

         // When the new head is the byte being written this edge it is not in
         // the array yet, so bypass it straight into the output register.
         if (wr_ok && (rd_ptr_d == wr_ptr_q)) begin
            tx_data_d = wr_data;
         end else if (level_d != '0) begin
            tx_data_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign level    = level_q;
   assign full     = full_w;
   assign empty    = (level_q == '0);
   assign low_irq  = (level_q <= LW'(LOW_WM));
   assign ovf      = ovf_q;
   assign unf      = unf_q;

endmodule : uart_tx_fifo
